// File: rtl/pe_ctrl_pkg.sv
// Shared widths, sizes and state encoding for the PE sequencer.
package pe_ctrl_pkg;

  localparam int unsigned DATA_WIDTH    = 16;
  localparam int unsigned INST_WIDTH    = 32;
  localparam int unsigned DM_ADDR_WIDTH = 8;
  localparam int unsigned IM_DEPTH      = 64;
  localparam int unsigned WB_LAT        = 6;

  localparam int unsigned BUS_WIDTH = DATA_WIDTH * 2;
  localparam int unsigned IM_AW     = $clog2(IM_DEPTH);
  localparam int unsigned CNT_W     = IM_AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_SHIFT = 2'd3
  } state_t;

endpackage

// File: rtl/pe_ctrl_inst_buf.sv
// Program buffer: synchronous write, registered read with enable.
module pe_inst_buf
  import pe_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [IM_AW-1:0]      waddr,
  input  logic [INST_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [IM_AW-1:0]      raddr,
  output logic [INST_WIDTH-1:0] rdata
);

  logic [INST_WIDTH-1:0] mem [IM_DEPTH];

  // Storage array carries no reset so it maps onto distributed RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/pe_ctrl.sv
// Per-PE sequencer: LOAD/SHIFT write strobes, program issue with aligned
// write-back strobe, and a small program buffer fed from the array bus.
module pe_ctrl
  import pe_ctrl_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     din_v,
  input  logic [BUS_WIDTH-1:0]     din,
  input  logic                     inst_in_v,
  input  logic [INST_WIDTH-1:0]    inst_in,
  input  logic                     clear_prog,
  input  logic                     start,
  input  logic                     shift_start,
  input  logic [DM_ADDR_WIDTH-1:0] shift_len,
  output logic                     wea,
  output logic                     web,
  output logic [BUS_WIDTH-1:0]     dina,
  output logic                     rden,
  output logic                     inst_v,
  output logic [INST_WIDTH-1:0]    inst,
  output logic                     shift_v,
  output logic                     wed,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  state_t state, state_nxt;

  logic [CNT_W-1:0]         count, count_nxt;
  logic [CNT_W-1:0]         rd_ptr, rd_ptr_nxt;
  logic [IM_AW-1:0]         wr_ptr, wr_ptr_nxt;
  logic [DM_ADDR_WIDTH-1:0] shift_cnt, shift_cnt_nxt;
  logic [WB_LAT-1:0]        wb_pipe;

  logic                 wea_nxt, web_nxt, rden_nxt, inst_v_nxt;
  logic                 shift_v_nxt, done_nxt, err_nxt, busy_nxt;
  logic [BUS_WIDTH-1:0] dina_nxt;
  logic                 buf_we, buf_re;
  logic [IM_AW-1:0]     buf_raddr;
  logic                 go_exec, go_shift, last_wb;

  // Read port returns buf[raddr] one cycle later, so the read issued with
  // inst_v_nxt lands in inst in the same cycle inst_v rises.
  pe_inst_buf u_buf (
    .clk   (clk),
    .rst   (rst),
    .we    (buf_we),
    .waddr (wr_ptr),
    .wdata (inst_in),
    .re    (buf_re),
    .raddr (buf_raddr),
    .rdata (inst)
  );

  assign go_exec  = start && !inst_in_v && !clear_prog;
  assign go_shift = shift_start && !go_exec;
  assign wed      = wb_pipe[WB_LAT-1];
  assign last_wb  = wb_pipe[WB_LAT-1] && (wb_pipe[WB_LAT-2:0] == '0);

  always_comb begin
    state_nxt     = state;
    count_nxt     = count;
    rd_ptr_nxt    = rd_ptr;
    wr_ptr_nxt    = wr_ptr;
    shift_cnt_nxt = shift_cnt;
    wea_nxt       = 1'b0;
    web_nxt       = 1'b0;
    dina_nxt      = dina;
    rden_nxt      = rden;
    inst_v_nxt    = 1'b0;
    shift_v_nxt   = 1'b0;
    done_nxt      = 1'b0;
    err_nxt       = 1'b0;
    buf_we        = 1'b0;
    buf_re        = 1'b0;
    buf_raddr     = rd_ptr[IM_AW-1:0];

    unique case (state)
      ST_IDLE: begin
        if (din_v) begin
          wea_nxt  = 1'b1;
          dina_nxt = din;
        end
        if (clear_prog) begin
          wr_ptr_nxt = '0;
          count_nxt  = '0;
        end else if (inst_in_v) begin
          if (count == CNT_W'(IM_DEPTH)) begin
            err_nxt = 1'b1;
          end else begin
            buf_we     = 1'b1;
            wr_ptr_nxt = wr_ptr + IM_AW'(1);
            count_nxt  = count + CNT_W'(1);
          end
        end
        if (go_exec) begin
          if (count == '0) begin
            done_nxt = 1'b1;
          end else begin
            state_nxt  = ST_EXEC;
            inst_v_nxt = 1'b1;
            rden_nxt   = 1'b1;
            buf_re     = 1'b1;
            buf_raddr  = '0;
            rd_ptr_nxt = CNT_W'(1);
          end
        end else if (go_shift) begin
          if (shift_len == '0) begin
            done_nxt = 1'b1;
          end else begin
            state_nxt     = ST_SHIFT;
            shift_v_nxt   = 1'b1;
            shift_cnt_nxt = shift_len - DM_ADDR_WIDTH'(1);
          end
        end
      end

      ST_EXEC: begin
        if (rd_ptr < count) begin
          inst_v_nxt = 1'b1;
          buf_re     = 1'b1;
          rd_ptr_nxt = rd_ptr + CNT_W'(1);
        end else begin
          state_nxt = ST_DRAIN;
        end
      end

      // Wait for the write-back strobe of the last issued instruction.
      ST_DRAIN: begin
        if (last_wb) begin
          state_nxt  = ST_IDLE;
          done_nxt   = 1'b1;
          rden_nxt   = 1'b0;
          rd_ptr_nxt = '0;
        end
      end

      ST_SHIFT: begin
        if (din_v) begin
          web_nxt  = 1'b1;
          dina_nxt = din;
        end
        if (shift_cnt != '0) begin
          shift_v_nxt   = 1'b1;
          shift_cnt_nxt = shift_cnt - DM_ADDR_WIDTH'(1);
        end else begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase

    busy_nxt = (state_nxt != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      count     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      shift_cnt <= '0;
      wb_pipe   <= '0;
      wea       <= 1'b0;
      web       <= 1'b0;
      dina      <= '0;
      rden      <= 1'b0;
      inst_v    <= 1'b0;
      shift_v   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      rd_ptr    <= rd_ptr_nxt;
      wr_ptr    <= wr_ptr_nxt;
      shift_cnt <= shift_cnt_nxt;
      wb_pipe   <= {wb_pipe[WB_LAT-2:0], inst_v};
      wea       <= wea_nxt;
      web       <= web_nxt;
      dina      <= dina_nxt;
      rden      <= rden_nxt;
      inst_v    <= inst_v_nxt;
      shift_v   <= shift_v_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
    end
  end

endmodule

// File: tb/tb_pe_ctrl.sv
// Directed bench for pe_ctrl with hand-computed expectations.
module tb_pe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        din_v;
  logic [31:0] din;
  logic        inst_in_v;
  logic [31:0] inst_in;
  logic        clear_prog;
  logic        start;
  logic        shift_start;
  logic [7:0]  shift_len;
  logic        wea, web, rden, inst_v, shift_v, wed, busy, done, err;
  logic [31:0] dina;
  logic [31:0] inst;

  int errors = 0;
  int checks = 0;

  pe_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .din_v       (din_v),
    .din         (din),
    .inst_in_v   (inst_in_v),
    .inst_in     (inst_in),
    .clear_prog  (clear_prog),
    .start       (start),
    .shift_start (shift_start),
    .shift_len   (shift_len),
    .wea         (wea),
    .web         (web),
    .dina        (dina),
    .rden        (rden),
    .inst_v      (inst_v),
    .inst        (inst),
    .shift_v     (shift_v),
    .wed         (wed),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Strobe vector: {wea,web,rden,inst_v,shift_v,wed,busy,done,err}
  function automatic logic [8:0] strobes();
    return {wea, web, rden, inst_v, shift_v, wed, busy, done, err};
  endfunction

  logic [31:0] prog [3];
  int          issued;
  int          done_at;

  initial begin
    prog[0] = 32'h010203;
    prog[1] = 32'h040506;
    prog[2] = 32'h070809;

    rst = 1'b1; din_v = 1'b0; din = '0; inst_in_v = 1'b0; inst_in = '0;
    clear_prog = 1'b0; start = 1'b0; shift_start = 1'b0; shift_len = '0;
    repeat (3) tick();
    check("reset_strobes", 64'(strobes()), 64'h0);
    check("reset_data", {dina, inst}, 64'h0);
    rst = 1'b0;
    tick();

    // LOAD: one word per cycle, latency 1
    for (int i = 0; i < 4; i++) begin
      din_v = 1'b1;
      din   = 32'((i + 1) * 32'h11);
      tick();
      check("load_wea", 64'(wea), 64'h1);
      check("load_dina", 64'(dina), 64'((i + 1) * 32'h11));
    end
    din_v = 1'b0;
    tick();
    check("load_idle_wea", 64'(wea), 64'h0);

    // Program three instructions, then run
    for (int i = 0; i < 3; i++) begin
      inst_in_v = 1'b1;
      inst_in   = prog[i];
      tick();
    end
    inst_in_v = 1'b0;
    start = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      tick();
      start = 1'b0;
      din_v = (c == 2);
      din   = 32'hDEAD;
      // {wea,inst_v,wed,done,busy,rden}
      check($sformatf("exec_c%0d", c), 64'({wea, inst_v, wed, done, busy, rden}),
            64'({1'b0, (c >= 1 && c <= 3), (c >= 7 && c <= 9), (c == 10),
                 (c <= 9), (c <= 9)}));
      if (c >= 1 && c <= 3) check($sformatf("exec_inst_c%0d", c), 64'(inst), 64'(prog[c-1]));
    end
    din_v = 1'b0;

    // Empty program
    clear_prog = 1'b1;
    tick();
    clear_prog = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("empty_t1", 64'({inst_v, done, busy}), 64'b010);
    for (int c = 2; c <= 9; c++) begin
      tick();
      check($sformatf("empty_c%0d", c), 64'({inst_v, wed, done, busy}), 64'h0);
    end

    // Overflow: 65 words, the last one dropped with an err pulse
    for (int i = 0; i < 65; i++) begin
      inst_in_v = 1'b1;
      inst_in   = 32'h100 + 32'(i);
      tick();
      if (i >= 63) check($sformatf("ovf_err_%0d", i), 64'(err), 64'(i == 64));
    end
    inst_in_v = 1'b0;
    tick();
    check("ovf_err_clear", 64'(err), 64'h0);
    start   = 1'b1;
    issued  = 0;
    done_at = 0;
    for (int c = 1; c <= 100 && done_at == 0; c++) begin
      tick();
      start = 1'b0;
      if (inst_v) begin
        check("ovf_inst", 64'(inst), 64'(32'h100 + 32'(issued)));
        issued++;
      end
      if (done) done_at = c;
    end
    check("ovf_issued", 64'(issued), 64'd64);
    check("ovf_done_at", 64'(done_at), 64'd71);

    // SHIFT with length 5 and din_v during the phase
    shift_len   = 8'd5;
    shift_start = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      shift_start = 1'b0;
      // {wea,web,shift_v,done,busy}
      check($sformatf("shift_c%0d", c), 64'({wea, web, shift_v, done, busy}),
            64'({1'b0, (c == 3 || c == 5), (c <= 5), (c == 6), (c <= 5)}));
      if (c == 3 || c == 5) check($sformatf("shift_dina_c%0d", c), 64'(dina), 64'(32'hA000 + 32'(c - 1)));
      din_v = (c == 2 || c == 4);
      din   = 32'hA000 + 32'(c);
    end
    din_v = 1'b0;

    // SHIFT with length 0
    shift_len   = 8'd0;
    shift_start = 1'b1;
    tick();
    shift_start = 1'b0;
    check("shift0_t1", 64'({shift_v, done, busy}), 64'b010);
    tick();
    check("shift0_t2", 64'({shift_v, done, busy}), 64'b000);

    // Asynchronous reset in the middle of a run
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("pre_rst_busy", 64'(busy), 64'h1);
    #3 rst = 1'b1;
    #1;
    check("rst_mid_strobes", 64'(strobes()), 64'h0);
    check("rst_mid_data", {dina, inst}, 64'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_after_busy", 64'(busy), 64'h0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("rst_count_cleared", 64'({inst_v, done, busy}), 64'b010);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
